// File: rtl/fetch_branch_predictor.sv
// -----------------------------------------------------------------------------
// fetch_branch_predictor
//   IF-stage dynamic branch predictor. A direct-mapped branch target buffer
//   with a 2-bit saturating counter per entry predicts a fetch redirect every
//   cycle. The ID-stage resolver (beq/bne/j) reports the real outcome, which
//   trains the table and raises a mispredict with the correct recovery PC.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   lookupPC         PC being fetched in IF
//   predTaken        redirect fetch to predTarget
//   predTarget       predicted target (0 when predTaken=0)
//   updValid         ID resolved a control instruction this cycle
//   updJump          resolved instruction is an unconditional j
//   updPC            PC of the resolved instruction
//   updTaken         actual outcome (1 for j)
//   updTarget        actual target
//   updPredTaken     prediction that travelled with the instruction
//   updPredTarget    predicted target that travelled with the instruction
//   mispredict       prediction was wrong; flush IF and fetch recoverPC
//   recoverPC        correct next PC (updTarget if taken, else updPC+4)
//   hitCount         saturating count of correctly predicted updates
//   missCount        saturating count of mispredicts
// -----------------------------------------------------------------------------
module fetch_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookupPC,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        updValid,
  input  logic        updJump,
  input  logic [31:0] updPC,
  input  logic        updTaken,
  input  logic [31:0] updTarget,
  input  logic        updPredTaken,
  input  logic [31:0] updPredTarget,
  output logic        mispredict,
  output logic [31:0] recoverPC,
  output logic [15:0] hitCount,
  output logic [15:0] missCount
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid   [ENTRIES];
  logic [TAG_W-1:0] tags    [ENTRIES];
  logic [31:0]      targets [ENTRIES];
  logic [1:0]       ctrs    [ENTRIES];

  // Instructions are word aligned, so PC[1:0] carries no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookupPC[1:0], updPC[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup: zero-cycle read of the pre-update table (no write bypass).
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = lookupPC[IDX_W+1:2];
  assign lk_tag = lookupPC[31:IDX_W+2];
  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    predTaken  = 1'b0;
    predTarget = 32'h0;
    if (lk_hit && ctrs[lk_idx][1]) begin
      predTaken  = 1'b1;
      predTarget = targets[lk_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict detection and recovery PC, straight from the update port.
  // A correct direction with the wrong target still needs a redirect.
  // ---------------------------------------------------------------------------
  assign mispredict = updValid &&
                      ((updTaken != updPredTaken) ||
                       (updTaken && updPredTaken && (updTarget != updPredTarget)));
  assign recoverPC  = updTaken ? updTarget : (updPC + 32'd4);

  // ---------------------------------------------------------------------------
  // Table training
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign up_idx = updPC[IDX_W+1:2];
  assign up_tag = updPC[31:IDX_W+2];
  assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

  // NOTE: the table is small and built from flops, so it is cleared on reset
  // like any other state; a RAM-based table could not be reset this way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        // NOTE: sequential state always uses non-blocking assignment so every
        // flop samples pre-edge values regardless of statement order.
        valid[i]   <= 1'b0;
        tags[i]    <= '0;
        targets[i] <= 32'h0;
        ctrs[i]    <= 2'b01;
      end
    end else if (updValid) begin
      if (up_hit) begin
        if (updJump) begin
          ctrs[up_idx]    <= 2'b11;
          targets[up_idx] <= updTarget;
        end else if (updTaken) begin
          if (ctrs[up_idx] != 2'b11) ctrs[up_idx] <= ctrs[up_idx] + 2'b01;
          targets[up_idx] <= updTarget;
        end else begin
          if (ctrs[up_idx] != 2'b00) ctrs[up_idx] <= ctrs[up_idx] - 2'b01;
        end
      end else if (updTaken) begin
        // Miss on a taken branch: allocate over whatever aliases this slot.
        valid[up_idx]   <= 1'b1;
        tags[up_idx]    <= up_tag;
        targets[up_idx] <= updTarget;
        ctrs[up_idx]    <= updJump ? 2'b11 : 2'b10;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accuracy counters: each resolved update bumps exactly one of them.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hitCount  <= 16'h0;
      missCount <= 16'h0;
    end else if (updValid) begin
      if (mispredict) begin
        if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
      end else begin
        if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_fetch_branch_predictor
//   Directed test of fetch_branch_predictor with hand-computed expectations.
//   Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
//   unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_fetch_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookupPC;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        updValid;
  logic        updJump;
  logic [31:0] updPC;
  logic        updTaken;
  logic [31:0] updTarget;
  logic        updPredTaken;
  logic [31:0] updPredTarget;
  logic        mispredict;
  logic [31:0] recoverPC;
  logic [15:0] hitCount;
  logic [15:0] missCount;

  int n_checks = 0;
  int n_fails  = 0;

  fetch_branch_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .lookupPC     (lookupPC),
    .predTaken    (predTaken),
    .predTarget   (predTarget),
    .updValid     (updValid),
    .updJump      (updJump),
    .updPC        (updPC),
    .updTaken     (updTaken),
    .updTarget    (updTarget),
    .updPredTaken (updPredTaken),
    .updPredTarget(updPredTarget),
    .mispredict   (mispredict),
    .recoverPC    (recoverPC),
    .hitCount     (hitCount),
    .missCount    (missCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one update on the port (combinational outputs settle after #1).
  task automatic upd(input logic jump, input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
    updValid      = 1'b1;
    updJump       = jump;
    updPC         = pc;
    updTaken      = taken;
    updTarget     = tgt;
    updPredTaken  = ptaken;
    updPredTarget = ptgt;
    #1;
  endtask

  // Commit the presented update on the next edge, then idle the port.
  task automatic step();
    @(posedge clk);
    #1;
    updValid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc, input string tag,
                      input logic exp_taken, input logic [31:0] exp_tgt);
    lookupPC = pc;
    #1;
    check({tag, ".predTaken"}, {31'h0, predTaken}, {31'h0, exp_taken});
    check({tag, ".predTarget"}, predTarget, exp_tgt);
  endtask

  initial begin
    rst           = 1'b1;
    lookupPC      = 32'h40;
    updValid      = 1'b0;
    updJump       = 1'b0;
    updPC         = 32'h1000;
    updTaken      = 1'b0;
    updTarget     = 32'h0;
    updPredTaken  = 1'b0;
    updPredTarget = 32'h0;
    #2;
    check("rst.predTaken",  {31'h0, predTaken}, 32'h0);
    check("rst.predTarget", predTarget, 32'h0);
    check("rst.mispredict", {31'h0, mispredict}, 32'h0);
    check("rst.recoverPC",  recoverPC, 32'h1004);
    check("rst.hitCount",   {16'h0, hitCount}, 32'h0);
    check("rst.missCount",  {16'h0, missCount}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Cold miss, with lookup of the same PC in the same cycle (no bypass).
    upd(1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    check("cold.mispredict", {31'h0, mispredict}, 32'h1);
    check("cold.recoverPC",  recoverPC, 32'h100);
    check("cold.sameCycle",  {31'h0, predTaken}, 32'h0);
    step();                                          // ctr=2, miss=1
    look(32'h40, "cold.next", 1'b1, 32'h100);
    check("cold.missCount", {16'h0, missCount}, 32'd1);

    // Hysteresis on 0x40.
    upd(1'b0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    check("hyst.correct", {31'h0, mispredict}, 32'h0);
    step();                                          // ctr=3, hit=1
    upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    check("hyst.nt1.mispredict", {31'h0, mispredict}, 32'h1);
    check("hyst.nt1.recoverPC",  recoverPC, 32'h44);
    step();                                          // ctr=2, miss=2
    look(32'h40, "hyst.ctr2", 1'b1, 32'h100);
    upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    step();                                          // ctr=1, miss=3
    look(32'h40, "hyst.ctr1", 1'b0, 32'h0);
    upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    step();                                          // ctr=0, hit=2
    upd(1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    step();                                          // ctr=0, hit=3
    upd(1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    step();                                          // ctr=1, miss=4
    look(32'h40, "hyst.noUnderflow", 1'b0, 32'h0);
    upd(1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    step();                                          // ctr=2, miss=5
    look(32'h40, "hyst.retrain", 1'b1, 32'h100);
    check("hyst.hitCount",  {16'h0, hitCount}, 32'd3);
    check("hyst.missCount", {16'h0, missCount}, 32'd5);

    // Jump install at 0x80: same index as 0x40, so it also evicts it.
    upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    check("jump.mispredict", {31'h0, mispredict}, 32'h1);
    check("jump.recoverPC",  recoverPC, 32'h200);
    step();                                          // ctr=3, miss=6
    look(32'h40, "alias.evicted", 1'b0, 32'h0);
    look(32'h80, "jump.installed", 1'b1, 32'h200);
    upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h200);
    check("jump.repeat.mispredict", {31'h0, mispredict}, 32'h0);
    step();                                          // hit=4
    check("jump.hitCount", {16'h0, hitCount}, 32'd4);
    // One not-taken update leaves a ctr=3 entry predicting taken.
    upd(1'b0, 32'h80, 1'b0, 32'h0, 1'b1, 32'h200);
    step();                                          // ctr=2, miss=7
    look(32'h80, "jump.ctr3", 1'b1, 32'h200);

    // Right direction, wrong target.
    upd(1'b0, 32'h80, 1'b1, 32'h100, 1'b1, 32'h104);
    check("tgt.mispredict", {31'h0, mispredict}, 32'h1);
    check("tgt.recoverPC",  recoverPC, 32'h100);
    step();                                          // ctr=3, miss=8
    look(32'h80, "tgt.retarget", 1'b1, 32'h100);

    // Not-taken recovery wraps past the top of the address space.
    upd(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
    check("wrap.mispredict", {31'h0, mispredict}, 32'h1);
    check("wrap.recoverPC",  recoverPC, 32'h0);
    step();                                          // miss=9, no table change
    look(32'hFFFF_FFFC, "wrap.noAlloc", 1'b0, 32'h0);

    // Idle update port: no mispredict, no state change.
    updValid      = 1'b0;
    updTaken      = 1'b1;
    updPredTaken  = 1'b0;
    #1;
    check("idle.mispredict", {31'h0, mispredict}, 32'h0);
    @(posedge clk);
    #1;
    check("idle.hitCount",  {16'h0, hitCount}, 32'd4);
    check("idle.missCount", {16'h0, missCount}, 32'd9);

    // Asynchronous reset between edges.
    lookupPC = 32'h80;
    #1;
    check("prerst.predTaken", {31'h0, predTaken}, 32'h1);
    rst = 1'b1;
    #1;
    check("midrst.predTaken", {31'h0, predTaken}, 32'h0);
    check("midrst.hitCount",  {16'h0, hitCount}, 32'h0);
    check("midrst.missCount", {16'h0, missCount}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    look(32'h80, "postrst", 1'b0, 32'h0);

    // Drive missCount to saturation with back-to-back mispredicts.
    upd(1'b0, 32'h300, 1'b1, 32'h500, 1'b0, 32'h0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat.reach", {16'h0, missCount}, 32'h0000_FFFF);
    repeat (3) @(posedge clk);
    #1;
    check("sat.hold",     {16'h0, missCount}, 32'h0000_FFFF);
    check("sat.hitCount", {16'h0, hitCount}, 32'h0);
    updValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fetch_branch_predictor.md
Name: fetch_branch_predictor

Overview:
IF-stage dynamic branch predictor: direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry. Each cycle it predicts next-PC redirection for the instruction being fetched. The ID-stage branch resolver (beq/bne/j) reports the resolved outcome back through the update port. The block trains its table from that report and flags mispredictions so fetch can flush and recover.

Parameters:
ENTRIES, 16, number of BTB entries (power of two, 4..64)
IDX_W, 4, log2(ENTRIES); index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
lookupPC  in  32  PC of instruction in IF
predTaken  out  1  prediction: redirect fetch
predTarget  out  32  predicted target (valid when predTaken=1)
updValid  in  1  ID stage resolved a control instruction this cycle
updJump  in  1  resolved instruction is unconditional j
updPC  in  32  PC of the resolved instruction
updTaken  in  1  actual outcome (1 for j)
updTarget  in  32  actual target
updPredTaken  in  1  predTaken that accompanied this instruction down the pipe
updPredTarget  in  32  predTarget that accompanied it
mispredict  out  1  prediction was wrong; fetch must flush IF and redirect
recoverPC  out  32  correct next PC when mispredict=1
hitCount  out  16  saturating count of updates whose prediction was correct
missCount  out  16  saturating count of mispredicts

Behaviour:
- Entry state: valid(1), tag(32-IDX_W-2), target(32), ctr(2). ctr 0/1 = not taken, 2/3 = taken.
- Reset (async, immediate): all valid=0, all ctr=2'b01, all targets/tags=0, hitCount=missCount=0. Outputs settle to predTaken=0, predTarget=0, mispredict=0 and recoverPC=updPC+4 from the current inputs.
- Lookup (combinational, 0-cycle): hit = valid[idx] & tag[idx]==lookupPC tag. predTaken = hit & ctr[idx][1]. predTarget = target[idx] when predTaken, else 0.
- Mispredict (combinational from update port, gated by updValid):
  - Condition: updTaken != updPredTaken, OR (updTaken & updPredTaken & updTarget != updPredTarget).
  - recoverPC = updTarget if updTaken, else updPC+4 (32-bit, wraps modulo 2^32).
- Table update (registered, on clk edge with updValid=1, index/tag from updPC):
  - Entry hit, conditional: ctr saturating ±1 (increment if updTaken, decrement otherwise; 3 stays 3, 0 stays 0). If updTaken, target <= updTarget.
  - Entry hit, updJump: ctr <= 3, target <= updTarget.
  - Entry miss and updTaken: allocate and overwrite the existing entry (alias replacement). valid<=1, tag, target<=updTarget. ctr <= 3 if updJump, else 2.
  - Entry miss and not taken: no table change.
- Counters (same clock edge): when updValid, exactly one of hitCount/missCount increments, saturating at 16'hFFFF.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents (no bypass). The new value is visible from the next cycle.
- updValid=0: no state changes, mispredict=0.
- Reset asserted mid-operation: table and counters clear immediately. Predictions after reset deassertion are all not-taken until retrained.

Test Plan:
- Cold miss: after reset, lookupPC=0x40 -> predTaken=0. Update updPC=0x40, taken, target=0x100, updPredTaken=0 -> mispredict=1, recoverPC=0x100. Next cycle lookup 0x40 -> predTaken=1, predTarget=0x100, ctr=2.
- Hysteresis: entry 0x40 at ctr=3, one not-taken update -> ctr=2, still predicts taken. Second not-taken -> ctr=1, predTaken=0. Further not-taken updates keep ctr at 0, no underflow.
- Jump install: updJump=1, updPC=0x80, target=0x200, updPredTaken=0 -> mispredict=1, recoverPC=0x200, ctr=3. Repeat update with updPredTaken=1, updPredTarget=0x200 -> mispredict=0, hitCount increments.
- Alias and target mismatch: with ENTRIES=16, train 0x40 taken. Taken update at 0x80 (same index, different tag) replaces it; lookup 0x40 -> predTaken=0. Taken update with updPredTarget=0x104 vs updTarget=0x100 -> mispredict=1, recoverPC=0x100.
- Same-cycle read/write: lookupPC=updPC=0x40 on the first taken update -> predTaken=0 that cycle, 1 the next cycle. Not-taken mispredict at updPC=0xFFFFFFFC -> recoverPC=0x00000000.
- Reset mid-run: trained table, assert rst asynchronously between edges -> predTaken drops to 0 immediately, hitCount/missCount=0. Preload missCount to 0xFFFF -> further mispredicts hold it at 0xFFFF.
